// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for a 6-digit common-anode display (HH:MM:SS).
// Each slot has one dead cycle for capture and anti-ghosting, then drive cycles.

module seg7_decode (
  input  logic [3:0] i_val,
  output logic [6:0] o_seg
);
  // {g,f,e,d,c,b,a}, active-low; non-BCD codes show a dash
  always_comb begin
    o_seg = 7'h3F;
    case (i_val)
      4'd0: o_seg = 7'h40;
      4'd1: o_seg = 7'h79;
      4'd2: o_seg = 7'h24;
      4'd3: o_seg = 7'h30;
      4'd4: o_seg = 7'h19;
      4'd5: o_seg = 7'h12;
      4'd6: o_seg = 7'h02;
      4'd7: o_seg = 7'h78;
      4'd8: o_seg = 7'h00;
      4'd9: o_seg = 7'h10;
      default: o_seg = 7'h3F;
    endcase
  end
endmodule

module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 6,
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    lzb,
  input  logic                    blank,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);
  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);
  localparam logic [2:0]       IDX_LAST = 3'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]      r_cnt;
  logic [2:0]            r_idx;
  logic [FRM_W-1:0]      r_frm;
  logic                  r_blink_phase;
  logic                  r_wrap;
  logic [3:0]            r_hold_val;
  logic                  r_hold_dp;
  logic [6:0]            r_seg;
  logic                  r_dp;
  logic [NUM_DIGITS-1:0] r_an;
  logic                  r_frame_tick;

  logic                  w_slot_end;
  logic                  w_frame_end;
  logic                  w_dead;
  logic                  w_suppress;
  logic [3:0]            w_cur_val;
  logic                  w_cur_dp;
  logic                  w_cur_blink;
  logic [6:0]            w_dec_seg;
  logic [NUM_DIGITS-1:0] w_an_on;

  assign w_slot_end  = (r_cnt == CNT_LAST);
  assign w_frame_end = w_slot_end && (r_idx == IDX_LAST);
  assign w_dead      = (r_cnt == '0);
  assign w_an_on     = ~(NUM_DIGITS'(1) << r_idx);

  always_comb begin
    w_cur_val   = '0;
    w_cur_dp    = 1'b0;
    w_cur_blink = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == 3'(i)) begin
        w_cur_val   = digits[4*i +: 4];
        w_cur_dp    = dp_mask[i];
        w_cur_blink = blink_mask[i];
      end
    end
  end

  // Priority order is irrelevant to the pins: every rule forces the same all-off state
  assign w_suppress = w_dead || blank || (r_blink_phase && w_cur_blink) ||
                      (lzb && (r_idx == IDX_LAST) && (r_hold_val == 4'd0));

  seg7_decode u_dec (
    .i_val (r_hold_val),
    .o_seg (w_dec_seg)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt         <= '0;
      r_idx         <= '0;
      r_frm         <= '0;
      r_blink_phase <= 1'b0;
      r_wrap        <= 1'b0;
      r_hold_val    <= '0;
      r_hold_dp     <= 1'b0;
      r_seg         <= 7'h7F;
      r_dp          <= 1'b1;
      r_an          <= '1;
      r_frame_tick  <= 1'b0;
    end else begin
      if (w_slot_end) begin
        r_cnt <= '0;
        r_idx <= (r_idx == IDX_LAST) ? 3'd0 : r_idx + 3'd1;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      if (w_frame_end) begin
        if (r_frm == FRM_LAST) begin
          r_frm         <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_frm <= r_frm + FRM_W'(1);
        end
      end

      if (w_dead) begin
        r_hold_val <= w_cur_val;
        r_hold_dp  <= w_cur_dp;
      end

      // Tick lands alongside the slot-0 dead cycle, matching the output latency
      r_wrap       <= w_frame_end;
      r_frame_tick <= r_wrap;

      r_seg <= w_suppress ? 7'h7F : w_dec_seg;
      r_dp  <= w_suppress ? 1'b1  : ~r_hold_dp;
      r_an  <= w_suppress ? '1    : w_an_on;
    end
  end

  assign seg        = r_seg;
  assign dp         = r_dp;
  assign an         = r_an;
  assign frame_tick = r_frame_tick;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver with SCAN_DIV=4, BLINK_FRAMES=2 (24 cycles per frame).
// Expected pin states are queued per output cycle and checked at the falling edge.

module tb_seg7_scan_driver;
  logic        clk;
  logic        rst;
  logic [23:0] digits;
  logic [5:0]  dp_mask;
  logic [5:0]  blink_mask;
  logic        lzb;
  logic        blank;
  logic [6:0]  seg;
  logic        dp;
  logic [5:0]  an;
  logic        frame_tick;

  seg7_scan_driver #(.NUM_DIGITS(6), .SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .digits     (digits),
    .dp_mask    (dp_mask),
    .blink_mask (blink_mask),
    .lzb        (lzb),
    .blank      (blank),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          frame;
    int          slot;
    logic [23:0] digits;
    logic [5:0]  dpm;
    logic [5:0]  bm;
    logic        lzb;
    logic        blank;
    logic [5:0]  an;
    logic [6:0]  seg;
    logic        dp;
  } vec_t;

  typedef struct {
    int          cyc;
    logic [14:0] exp;
    string       name;
  } exp_t;

  vec_t tbl[$];
  exp_t q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc;

  // Output cycle index since reset release; cycle 0 is the first dead cycle
  always @(posedge clk or negedge rst)
    if (!rst) cyc <= -1;
    else      cyc <= cyc + 1;

  function automatic vec_t mk(input int f, input int s, input logic [23:0] d,
                              input logic [5:0] dpm, input logic [5:0] bm,
                              input logic l, input logic b, input logic [5:0] a,
                              input logic [6:0] sg, input logic p);
    vec_t v;
    v.frame = f; v.slot = s; v.digits = d; v.dpm = dpm; v.bm = bm;
    v.lzb = l; v.blank = b; v.an = a; v.seg = sg; v.dp = p;
    return v;
  endfunction

  task automatic check(input string nm, input logic [14:0] act, input logic [14:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got an=%h seg=%h dp=%b ft=%b, want an=%h seg=%h dp=%b ft=%b",
               nm, act[14:9], act[8:2], act[1], act[0], exp[14:9], exp[8:2], exp[1], exp[0]);
    end
  endtask

  task automatic push_exp(input int c, input logic [5:0] a, input logic [6:0] sg,
                          input logic p, input string nm);
    exp_t e;
    e.cyc  = c;
    e.exp  = {a, sg, p, ((c % 24) == 0) && (c > 0)};
    e.name = $sformatf("%s@%0d", nm, c);
    q.push_back(e);
  endtask

  task automatic push_slot(input int f, input int s, input logic [5:0] a,
                           input logic [6:0] sg, input logic p);
    int base;
    string nm;
    base = 24*f + 4*s;
    nm = $sformatf("f%0d_s%0d", f, s);
    push_exp(base, 6'h3F, 7'h7F, 1'b1, {nm, "_dead"});
    for (int k = 1; k < 4; k++) push_exp(base + k, a, sg, p, nm);
  endtask

  task automatic wait_cyc(input int n);
    int g;
    g = 0;
    while (cyc != n && g < 3000) begin
      @(negedge clk);
      g++;
    end
    if (cyc != n) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_cyc: cycle %0d not reached (at %0d)", n, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        mon_e = q.pop_front();
        if (mon_e.cyc < cyc) begin
          n_vec++;
          n_err++;
          $display("FAIL %s: not observed, now at cycle %0d", mon_e.name, cyc);
        end else begin
          check(mon_e.name, {an, seg, dp, frame_tick}, mon_e.exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cur_frame;
    int g;

    // Frame 0: plain scan
    tbl.push_back(mk(0, 0, 24'h123456, 6'h00, 6'h00, 0, 0, 6'h3E, 7'h02, 1));
    tbl.push_back(mk(0, 1, 24'h123456, 6'h00, 6'h00, 0, 0, 6'h3D, 7'h12, 1));
    tbl.push_back(mk(0, 2, 24'h123456, 6'h00, 6'h00, 0, 0, 6'h3B, 7'h19, 1));
    tbl.push_back(mk(0, 3, 24'h123456, 6'h00, 6'h00, 0, 0, 6'h37, 7'h30, 1));
    tbl.push_back(mk(0, 4, 24'h123456, 6'h00, 6'h00, 0, 0, 6'h2F, 7'h24, 1));
    tbl.push_back(mk(0, 5, 24'h123456, 6'h00, 6'h00, 0, 0, 6'h1F, 7'h79, 1));
    // Frame 1: leading-zero blank, invalid code, blink armed but phase 0
    tbl.push_back(mk(1, 0, 24'h095A00, 6'h00, 6'h03, 1, 0, 6'h3E, 7'h40, 1));
    tbl.push_back(mk(1, 1, 24'h095A00, 6'h00, 6'h03, 1, 0, 6'h3D, 7'h40, 1));
    tbl.push_back(mk(1, 2, 24'h095A00, 6'h00, 6'h03, 1, 0, 6'h3B, 7'h3F, 1));
    tbl.push_back(mk(1, 3, 24'h095A00, 6'h00, 6'h03, 1, 0, 6'h37, 7'h12, 1));
    tbl.push_back(mk(1, 4, 24'h095A00, 6'h00, 6'h03, 1, 0, 6'h2F, 7'h10, 1));
    tbl.push_back(mk(1, 5, 24'h095A00, 6'h00, 6'h03, 1, 0, 6'h3F, 7'h7F, 1));
    // Frames 2-3: blink phase 1, slots 0/1 dark
    tbl.push_back(mk(2, 0, 24'h123456, 6'h00, 6'h03, 0, 0, 6'h3F, 7'h7F, 1));
    tbl.push_back(mk(2, 1, 24'h123456, 6'h00, 6'h03, 0, 0, 6'h3F, 7'h7F, 1));
    tbl.push_back(mk(2, 2, 24'h123456, 6'h00, 6'h03, 0, 0, 6'h3B, 7'h19, 1));
    tbl.push_back(mk(2, 5, 24'h123456, 6'h00, 6'h03, 0, 0, 6'h1F, 7'h79, 1));
    tbl.push_back(mk(3, 0, 24'h095A00, 6'h00, 6'h03, 0, 0, 6'h3F, 7'h7F, 1));
    tbl.push_back(mk(3, 2, 24'h095A00, 6'h00, 6'h03, 0, 0, 6'h3B, 7'h3F, 1));
    tbl.push_back(mk(3, 5, 24'h095A00, 6'h00, 6'h03, 0, 0, 6'h1F, 7'h40, 1));
    // Frame 4: blink phase back to 0
    tbl.push_back(mk(4, 0, 24'h095A00, 6'h00, 6'h03, 0, 0, 6'h3E, 7'h40, 1));
    tbl.push_back(mk(4, 1, 24'h095A00, 6'h00, 6'h03, 0, 0, 6'h3D, 7'h40, 1));
    tbl.push_back(mk(4, 5, 24'h095A00, 6'h00, 6'h03, 0, 0, 6'h1F, 7'h40, 1));
    // Frame 5: global blank
    tbl.push_back(mk(5, 0, 24'h123456, 6'h00, 6'h00, 0, 1, 6'h3F, 7'h7F, 1));
    tbl.push_back(mk(5, 3, 24'h123456, 6'h00, 6'h00, 0, 1, 6'h3F, 7'h7F, 1));
    tbl.push_back(mk(5, 5, 24'h123456, 6'h00, 6'h00, 0, 1, 6'h3F, 7'h7F, 1));
    // Frame 6: decimal points on slots 2 and 4
    tbl.push_back(mk(6, 0, 24'h123456, 6'h14, 6'h00, 0, 0, 6'h3E, 7'h02, 1));
    tbl.push_back(mk(6, 2, 24'h123456, 6'h14, 6'h00, 0, 0, 6'h3B, 7'h19, 0));
    tbl.push_back(mk(6, 3, 24'h123456, 6'h14, 6'h00, 0, 0, 6'h37, 7'h30, 1));
    tbl.push_back(mk(6, 4, 24'h123456, 6'h14, 6'h00, 0, 0, 6'h2F, 7'h24, 0));

    rst = 1'b0;
    digits = '0; dp_mask = '0; blink_mask = '0; lzb = 1'b0; blank = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("reset", {an, seg, dp, frame_tick}, {6'h3F, 7'h7F, 1'b1, 1'b0});
    @(negedge clk);
    rst = 1'b1;

    cur_frame = -1;
    foreach (tbl[r]) begin
      if (tbl[r].frame != cur_frame) begin
        wait_cyc(24*tbl[r].frame - 1);
        digits = tbl[r].digits; dp_mask = tbl[r].dpm; blink_mask = tbl[r].bm;
        lzb = tbl[r].lzb; blank = tbl[r].blank;
        cur_frame = tbl[r].frame;
      end
      push_slot(tbl[r].frame, tbl[r].slot, tbl[r].an, tbl[r].seg, tbl[r].dp);
    end

    // Mid-slot digit change is ignored until the next capture
    wait_cyc(24*7 - 1);
    digits = 24'h123456; dp_mask = '0; blink_mask = '0; lzb = 1'b0; blank = 1'b0;
    push_slot(7, 0, 6'h3E, 7'h02, 1'b1);
    wait_cyc(24*7 + 1);
    digits = 24'h123459;
    push_slot(8, 0, 6'h3E, 7'h10, 1'b1);
    push_exp(24*8 + 12, 6'h3F, 7'h7F, 1'b1, "f8_s3_dead");
    push_exp(24*8 + 13, 6'h37, 7'h30, 1'b1, "f8_s3");
    push_exp(24*8 + 14, 6'h37, 7'h30, 1'b1, "f8_s3");

    // Asynchronous reset at cnt=2 of slot 3
    wait_cyc(24*8 + 14);
    #1 rst = 1'b0;
    #1 check("async_rst", {an, seg, dp, frame_tick}, {6'h3F, 7'h7F, 1'b1, 1'b0});
    @(posedge clk);
    #1 check("rst_held", {an, seg, dp, frame_tick}, {6'h3F, 7'h7F, 1'b1, 1'b0});
    @(negedge clk);
    rst = 1'b1;
    push_slot(0, 0, 6'h3E, 7'h10, 1'b1);
    push_slot(0, 1, 6'h3D, 7'h12, 1'b1);
    wait_cyc(8);

    g = 0;
    while (q.size() > 0 && g < 100) begin
      @(negedge clk);
      #1 g++;
    end
    if (q.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
